// File: rtl/turnstile_pkg.sv
// Shared types and constants for the turnstile coin front end.
// Holds the debounce state encoding, slot count, bank width and default coin pricing.
package turnstile_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } deb_state_t;

  localparam int NUM_SLOTS    = 3;
  localparam int BANK_W       = 8;
  localparam int DEF_DEBOUNCE = 4;
  localparam int DEF_VAL0     = 5;
  localparam int DEF_VAL1     = 10;
  localparam int DEF_VAL2     = 25;
  localparam int DEF_PRICE    = 50;

  // True when two or more slots report a coin in the same cycle.
  function automatic logic multi_hot(input logic [NUM_SLOTS-1:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin slot: 2-flop synchronizer, debounce counter/FSM, and a one-cycle
// accept pulse registered on entry to the stable-high state.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sense,
  output logic accept
);
  import turnstile_pkg::*;

  localparam logic [3:0] DEB_C = 4'(DEBOUNCE_CYCLES);

  logic       sync1_r;
  logic       sync2_r;
  logic [3:0] cnt_r;
  deb_state_t state_r;
  logic       accept_r;

  // Synchronizer, debounce FSM and accept pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      cnt_r    <= 4'd0;
      state_r  <= S_LOW;
      accept_r <= 1'b0;
    end else begin
      sync1_r  <= sense;
      sync2_r  <= sync1_r;
      accept_r <= 1'b0;
      case (state_r)
        S_LOW: begin
          if (sync2_r) begin
            // A single required sample means the first high sample is already stable.
            if (DEB_C == 4'd1) begin
              state_r  <= S_HIGH;
              cnt_r    <= 4'd0;
              accept_r <= 1'b1;
            end else begin
              state_r <= S_RISE;
              cnt_r   <= 4'd1;
            end
          end else begin
            cnt_r <= 4'd0;
          end
        end
        S_RISE: begin
          if (!sync2_r) begin
            state_r <= S_LOW;
            cnt_r   <= 4'd0;
          end else if (cnt_r + 4'd1 == DEB_C) begin
            state_r  <= S_HIGH;
            cnt_r    <= 4'd0;
            accept_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        S_HIGH: begin
          if (!sync2_r) begin
            if (DEB_C == 4'd1) begin
              state_r <= S_LOW;
              cnt_r   <= 4'd0;
            end else begin
              state_r <= S_FALL;
              cnt_r   <= 4'd1;
            end
          end else begin
            cnt_r <= 4'd0;
          end
        end
        S_FALL: begin
          if (sync2_r) begin
            state_r <= S_HIGH;
            cnt_r   <= 4'd0;
          end else if (cnt_r + 4'd1 == DEB_C) begin
            state_r <= S_LOW;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= S_LOW;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign accept = accept_r;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: debounces three slots, arbitrates accepts, banks coin value
// and emits one credit pulse per PRICE banked (paused by inhibit).
module coin_acceptor
  import turnstile_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int VAL0            = DEF_VAL0,
  parameter int VAL1            = DEF_VAL1,
  parameter int VAL2            = DEF_VAL2,
  parameter int PRICE           = DEF_PRICE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        coin_sense,
  input  logic              inhibit,
  output logic              coin_out,
  output logic              reject,
  output logic [BANK_W-1:0] bank
);

  localparam logic [BANK_W:0] VAL0_C  = (BANK_W+1)'(VAL0);
  localparam logic [BANK_W:0] VAL1_C  = (BANK_W+1)'(VAL1);
  localparam logic [BANK_W:0] VAL2_C  = (BANK_W+1)'(VAL2);
  localparam logic [BANK_W:0] PRICE_C = (BANK_W+1)'(PRICE);
  localparam logic [BANK_W:0] BANK_MAX_C = {1'b0, {BANK_W{1'b1}}};

  logic [NUM_SLOTS-1:0] accept_s;
  logic [BANK_W-1:0]    bank_r;
  logic                 coin_out_r;
  logic                 reject_r;

  logic                 dispense_s;
  logic                 reject_s;
  logic [BANK_W:0]      add_s;
  logic [BANK_W:0]      base_s;
  logic [BANK_W:0]      sum_s;
  logic [BANK_W:0]      next_s;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .sense (coin_sense[i]),
      .accept(accept_s[i])
    );
  end

  // Accept arbitration and 9-bit bank arithmetic; overflow or collisions return the coin.
  always_comb begin
    dispense_s = ({1'b0, bank_r} >= PRICE_C) && !inhibit;
    case (accept_s)
      3'b001:  add_s = VAL0_C;
      3'b010:  add_s = VAL1_C;
      3'b100:  add_s = VAL2_C;
      default: add_s = {(BANK_W+1){1'b0}};
    endcase
    base_s = {1'b0, bank_r} - (dispense_s ? PRICE_C : {(BANK_W+1){1'b0}});
    sum_s  = base_s + add_s;
    if (multi_hot(accept_s) || (sum_s > BANK_MAX_C)) begin
      reject_s = 1'b1;
      next_s   = base_s;
    end else begin
      reject_s = 1'b0;
      next_s   = sum_s;
    end
  end

  // Output and bank registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_r     <= {BANK_W{1'b0}};
      coin_out_r <= 1'b0;
      reject_r   <= 1'b0;
    end else begin
      bank_r     <= next_s[BANK_W-1:0];
      coin_out_r <= dispense_s;
      reject_r   <= reject_s;
    end
  end

  assign bank     = bank_r;
  assign coin_out = coin_out_r;
  assign reject   = reject_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor with default parameters (D=4, PRICE=50).
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sense;
  logic       inhibit;
  logic       coin_out;
  logic       reject;
  logic [7:0] bank;

  int n_vec = 0;
  int n_err = 0;
  int n_coin = 0;
  int n_rej = 0;
  int bank_max = 0;
  int coin_base;
  int rej_base;

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(4),
    .VAL0(5),
    .VAL1(10),
    .VAL2(25),
    .PRICE(50)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coin_sense(sense),
    .inhibit   (inhibit),
    .coin_out  (coin_out),
    .reject    (reject),
    .bank      (bank)
  );

  // Pulse counters and peak bank, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (coin_out === 1'b1) n_coin++;
    if (reject === 1'b1) n_rej++;
    if ((^bank !== 1'bx) && (int'(bank) > bank_max)) bank_max = int'(bank);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic coin(input int slot, input int hi);
    sense[slot] = 1'b1;
    tick(hi);
    sense[slot] = 1'b0;
    tick(12);
  endtask

  initial begin
    rst_n   = 1'b0;
    sense   = 3'b000;
    inhibit = 1'b0;
    tick(2);
    rst_n = 1'b1;
    bank_max = 0;
    n_coin = 0;
    n_rej = 0;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_bank", {1'b0, bank}, 9'd0);
      check("idle_coin_out", {8'd0, coin_out}, 9'd0);
      check("idle_reject", {8'd0, reject}, 9'd0);
    end

    // Two quarters: 25, then 50, then one credit and an empty bank.
    coin(2, 10);
    check("q1_bank", {1'b0, bank}, 9'd25);
    check("q1_no_coin", 9'(n_coin), 9'd0);
    coin(2, 10);
    check("q2_peak", 9'(bank_max), 9'd50);
    check("q2_one_coin", 9'(n_coin), 9'd1);
    check("q2_bank", {1'b0, bank}, 9'd0);

    // Slot 0: 3-cycle glitch ignored, then bounce settling high gives one nickel.
    sense[0] = 1'b1; tick(3);
    sense[0] = 1'b0; tick(10);
    check("glitch_bank", {1'b0, bank}, 9'd0);
    sense[0] = 1'b1; tick(1);
    sense[0] = 1'b0; tick(1);
    sense[0] = 1'b1; tick(6);
    sense[0] = 1'b0; tick(12);
    check("bounce_bank", {1'b0, bank}, 9'd5);
    check("bounce_no_reject", 9'(n_rej), 9'd0);

    // Reset clears the bank.
    rst_n = 1'b0; tick(1);
    rst_n = 1'b1;
    check("rst_bank", {1'b0, bank}, 9'd0);
    check("rst_coin_out", {8'd0, coin_out}, 9'd0);

    // Inhibited: ten quarters bank to 250, a dime overflows and is rejected.
    coin_base = n_coin;
    rej_base  = n_rej;
    inhibit = 1'b1;
    for (int i = 0; i < 10; i++) coin(2, 10);
    check("inh_bank", {1'b0, bank}, 9'd250);
    check("inh_no_coin", 9'(n_coin - coin_base), 9'd0);
    coin(1, 10);
    check("ovf_reject", 9'(n_rej - rej_base), 9'd1);
    check("ovf_bank", {1'b0, bank}, 9'd250);

    // Release inhibit: five consecutive credits.
    inhibit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("burst_coin_out", {8'd0, coin_out}, 9'd1);
      check("burst_bank", {1'b0, bank}, 9'(200 - 50 * i));
    end
    tick(1);
    check("burst_end", {8'd0, coin_out}, 9'd0);
    check("burst_bank_end", {1'b0, bank}, 9'd0);

    // Slots 0 and 1 together: both returned, bank unchanged.
    rej_base = n_rej;
    sense[1:0] = 2'b11; tick(10);
    sense[1:0] = 2'b00; tick(12);
    check("dual_reject", 9'(n_rej - rej_base), 9'd1);
    check("dual_bank", {1'b0, bank}, 9'd0);

    // Build 45, then reset mid-debounce of a quarter.
    coin(2, 10);
    coin(1, 10);
    coin(1, 10);
    check("pre_rst_bank", {1'b0, bank}, 9'd45);
    coin_base = n_coin;
    sense[2] = 1'b1;
    tick(4);
    rst_n = 1'b0; tick(1);
    rst_n = 1'b1;
    check("mid_rst_bank", {1'b0, bank}, 9'd0);
    tick(6);
    check("redebounce_wait", {1'b0, bank}, 9'd0);
    tick(1);
    check("redebounce_bank", {1'b0, bank}, 9'd25);
    sense[2] = 1'b0;
    tick(12);
    check("post_rst_no_coin", 9'(n_coin - coin_base), 9'd0);
    check("post_rst_bank", {1'b0, bank}, 9'd25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage of the turnstile: converts three raw, bouncing coin-slot sensor lines into valid coin events, adds each coin's value to an 8-bit bank, and emits one single-cycle `coin` credit pulse per `PRICE` units banked. It sits directly upstream of the turnstile credit counter; `coin_out` connects to that counter's `coin` input. A `reject` pulse drives the coin-return solenoid.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples needed to change a slot's stable level; range 1..15.
- `VAL0` / `VAL1` / `VAL2`, defaults 5 / 10 / 25: value of a coin in slot 0 / 1 / 2, in cents.
- `PRICE`, default 50: cents per credit; range 1..255.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `coin_sense` input 3: raw slot sensors, asynchronous, high while a coin is in the slot.
- `inhibit` input 1: downstream cannot take credit; dispensing pauses.
- `coin_out` output 1: one-cycle credit pulse to the credit counter.
- `reject` output 1: one-cycle pulse; the coin must be returned.
- `bank` output 8: current banked cents, registered.

## Operation
- Reset, sampled at a rising edge with `rst_n` low:
  - `coin_out`=0, `reject`=0, `bank`=0.
  - Synchronizers and debounce counters = 0; all slots in state S_LOW.
  - Reset asserted mid-debounce or mid-dispense discards all partial progress; no pulse is emitted afterwards for that coin.
- Per slot: 2-flop synchronizer, then a debouncer FSM with states S_LOW, S_RISE, S_HIGH, S_FALL.
  - S_LOW: sync=1 → S_RISE with cnt=1.
  - S_RISE: sync=1 → cnt+1, and → S_HIGH when cnt reaches `DEBOUNCE_CYCLES`; sync=0 → S_LOW, cnt=0.
  - S_HIGH: sync=0 → S_FALL with cnt=1.
  - S_FALL: mirror of S_RISE, returning to S_LOW or S_HIGH.
  - Entering S_HIGH registers a one-cycle `accept[i]`.
  - Pulses shorter than `DEBOUNCE_CYCLES` samples produce nothing.
- Bank update, each edge, with `add` = value of the accepted slot:
  - `dispense` = (`bank` >= `PRICE`) && !`inhibit`.
  - `next` = `bank` − (`dispense` ? `PRICE` : 0) + `add`.
  - `coin_out` <= `dispense`.
- Accept rules:
  - More than one `accept` in the same cycle: all those coins rejected, `add`=0, `reject` <= 1.
  - `next` > 255, computed in 9 bits: the coin is rejected, `add`=0, `reject` <= 1, and the dispense part still applies. `bank` never wraps.
- Multiple credits: at most one `PRICE` is subtracted per cycle, so back-to-back `coin_out` pulses continue while `bank` >= `PRICE`.
- `inhibit` high: `bank` holds, apart from accepted coins, and `coin_out` stays 0.

## Timing
- `coin_sense[i]` rising and stable before edge 1:
  - Sync output high after edge 2.
  - Stable level high and `accept` registered at edge 2+D.
  - `bank` updated at edge 3+D.
  - `coin_out` high after edge 4+D, if `bank` >= `PRICE`.
  - With D=4: `bank` changes at edge 7, `coin_out` appears after edge 8.
- `reject` is asserted in the cycle after the offending `accept`, i.e. at the same edge as the `bank` update.
- No handshake: `coin_out` is fire-and-forget; `inhibit` is the only flow control, with a 1-cycle response.

## Structure
- `turnstile_pkg`: debounce state enum (S_LOW/S_RISE/S_HIGH/S_FALL), slot-count constant (3), default coin values and `PRICE`, bank width (8).
- Sub-module `coin_debounce`, instantiated 3×: synchronizer, counter, FSM, `accept` pulse.
- Top level: accept arbitration, 9-bit bank arithmetic, output registers.

## Test plan
- Reset, then idle 20 cycles → `bank`=0, `coin_out`=0, `reject`=0 throughout.
- Slot 2 (25) twice, clean pulses of 10 cycles → `bank` 25, then 50, then one `coin_out` pulse and `bank`=0.
- Slot 0 glitch of 3 cycles (D=4), then bounce pattern 1-0-1 ending in 6 stable highs → exactly one accept, `bank`=5.
- `inhibit`=1, then ten slot-2 coins (250) → `bank`=250, no `coin_out`; next slot-1 coin (10) → `reject` pulse, `bank`=250. Release `inhibit` → five consecutive `coin_out` cycles, `bank`=0.
- Slots 0 and 1 debounced in the same cycle → one `reject` pulse, `bank` unchanged.
- `rst_n` low for 1 cycle while slot 2 is in S_RISE with `bank`=45 → `bank`=0, no `coin_out` follows even if the sensor stays high; a new coin requires a full debounce from S_LOW.
